// File: rtl/apb_master_arbiter.sv
// Round-robin APB master for two requesters: accept -> SETUP -> ACCESS, response registered 3 cycles after accept with no wait states.
// req_ready is offered only in IDLE; requests stall while a transfer is in flight, and hung ACCESS phases abort after TIMEOUT cycles.
module apb_master_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              pclk,
  input  logic              prstn,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic [1:0]        req_ready,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_grant_q;
  logic        cmd_id_q;
  logic [7:0]  wait_q;
  logic        grant0, grant1;
  logic        accept;
  logic        timeout_hit;

  // Tie goes to whichever requester was not served last.
  always_comb begin
    grant0      = req_valid[0] && (!req_valid[1] || last_grant_q);
    grant1      = req_valid[1] && (!req_valid[0] || !last_grant_q);
    req_ready   = (state_q == IDLE) ? {grant1, grant0} : 2'b00;
    accept      = |(req_valid & req_ready);
    timeout_hit = !pready && (wait_q == WAIT_LAST);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign psel    = (state_q != IDLE);
  assign penable = (state_q == ACCESS);

  always_ff @(posedge pclk) begin
    if (!prstn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cmd_id_q     <= 1'b0;
      pwrite       <= 1'b0;
      paddr        <= '0;
      pwdata       <= '0;
      wait_q       <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            cmd_id_q     <= req_ready[1];
            last_grant_q <= req_ready[1];
            pwrite       <= req_ready[1] ? req_write[1] : req_write[0];
            paddr        <= req_ready[1] ? req1_addr  : req0_addr;
            pwdata       <= req_ready[1] ? req1_wdata : req0_wdata;
          end
        end
        SETUP: wait_q <= '0;
        ACCESS: begin
          if (pready) begin
            rsp_valid <= 1'b1;
            rsp_id    <= cmd_id_q;
            rsp_err   <= 1'b0;
            rsp_rdata <= pwrite ? '0 : prdata;
          end else if (timeout_hit) begin
            rsp_valid <= 1'b1;
            rsp_id    <= cmd_id_q;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomized scoreboard bench for apb_master_arbiter with a behavioural APB slave.
module tb_apb_master_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 15;
  localparam int HANG = 200;

  logic          pclk = 1'b0;
  logic          prstn;
  logic [1:0]    req_valid, req_write, req_ready;
  logic [AW-1:0] req0_addr, req1_addr, paddr;
  logic [DW-1:0] req0_wdata, req1_wdata, rsp_rdata, pwdata, prdata;
  logic          rsp_valid, rsp_id, rsp_err, psel, penable, pwrite, pready;

  always #5 pclk = ~pclk;

  apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .prstn(prstn), .req_valid(req_valid), .req_write(req_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  typedef struct { logic id; logic [DW-1:0] rdata; logic err; int cyc; } rsp_t;
  typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; int cyc; } apb_t;

  rsp_t          sb_q[$];
  apb_t          apb_q[$];
  logic [DW-1:0] mem[256];
  logic [DW-1:0] ref_mem[256];
  int            n_chk = 0, n_pass = 0;
  int            cyc = 0;
  int            slave_waits = 0, acc_cnt = 0;
  logic          mon_en = 1'b0;
  logic          lg;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Slave: raises pready after slave_waits low ACCESS cycles; never, if waits >= TO.
  always @(negedge pclk) begin
    if (psel && penable) begin
      if (acc_cnt == slave_waits) begin
        pready = 1'b1;
        prdata = pwrite ? 8'($urandom) : mem[paddr];
        if (pwrite) mem[paddr] = pwdata;
      end else begin
        pready = 1'b0;
        prdata = 8'($urandom);
      end
      acc_cnt++;
    end else begin
      pready  = 1'b0;
      prdata  = 8'($urandom);
      acc_cnt = 0;
    end
  end

  logic          hold_wr;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_wdata;

  always @(negedge pclk) begin
    if (mon_en) begin
      apb_t a;
      rsp_t r;
      chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
      chk("penable_without_psel", penable && !psel, 0);
      if (psel && !penable) begin
        chk("setup_expected", apb_q.size() > 0, 1);
        if (apb_q.size() > 0) begin
          a = apb_q.pop_front();
          chk("setup_paddr", paddr, a.addr);
          chk("setup_pwrite", pwrite, a.wr);
          chk("setup_pwdata", pwdata, a.wdata);
          chk("setup_cycle", cyc, a.cyc);
        end
        hold_wr = pwrite; hold_addr = paddr; hold_wdata = pwdata;
      end
      if (psel && penable)
        chk("access_stable", {pwrite, paddr, pwdata}, {hold_wr, hold_addr, hold_wdata});
      if (rsp_valid) begin
        chk("rsp_expected", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          r = sb_q.pop_front();
          chk("rsp_id", rsp_id, r.id);
          chk("rsp_rdata", rsp_rdata, r.rdata);
          chk("rsp_err", rsp_err, r.err);
          chk("rsp_cycle", cyc, r.cyc);
        end
      end
    end
  end

  // Issue one request pattern and hold it until accepted; the model predicts the winner and result.
  task automatic do_req(input logic [1:0] v, input logic [1:0] w, input logic [7:0] a0, input logic [7:0] d0,
                        input logic [7:0] a1, input logic [7:0] d1, input int waits);
    int      n = 0;
    logic    accepted = 1'b0;
    logic    win, wr, e;
    logic [7:0] addr, wd, er;
    rsp_t    r;
    apb_t    p;
    @(posedge pclk); #1;
    req_valid = v; req_write = w;
    req0_addr = a0; req0_wdata = d0; req1_addr = a1; req1_wdata = d1;
    while (!accepted && n < 100) begin
      @(negedge pclk);
      if ((req_valid & req_ready) != 2'b00) accepted = 1'b1;
      n++;
    end
    chk("accept_in_time", accepted, 1);
    if (accepted) begin
      win  = (v == 2'b11) ? ~lg : v[1];
      chk("grant", req_ready, win ? 2'b10 : 2'b01);
      lg   = win;
      wr   = w[win];
      addr = win ? a1 : a0;
      wd   = win ? d1 : d0;
      e    = (waits >= TO);
      er   = (wr || e) ? 8'h00 : ref_mem[addr];
      if (wr && !e) ref_mem[addr] = wd;
      slave_waits = waits;
      p.wr = wr; p.addr = addr; p.wdata = wd; p.cyc = cyc + 1;
      apb_q.push_back(p);
      r.id = win; r.rdata = er; r.err = e; r.cyc = e ? cyc + 2 + TO : cyc + 3 + waits;
      sb_q.push_back(r);
    end
  endtask

  // Request that appears and vanishes while the bus is busy: must never be accepted.
  task automatic glitch();
    @(posedge pclk); #1;
    req_valid = 2'($urandom_range(1, 3)); req_write = 2'($urandom);
    req0_addr = 8'($urandom); req1_addr = 8'($urandom);
    chk("busy_ready", req_ready, 0);
  endtask

  task automatic idle(input int n);
    @(posedge pclk); #1;
    req_valid = 2'b00;
    repeat (n) @(posedge pclk);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 300) begin
      @(posedge pclk);
      n++;
    end
    chk("drain", sb_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  r, wt;
    prstn = 1'b0; req_valid = 2'b00; req_write = 2'b00;
    req0_addr = '0; req0_wdata = '0; req1_addr = '0; req1_wdata = '0;
    pready = 1'b0; prdata = '0; lg = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("reset_apb", {psel, penable, pwrite, paddr, pwdata}, 0);
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_id, rsp_rdata}, 0);
    chk("reset_ready", req_ready, 0);
    @(posedge pclk); #1;
    prstn = 1'b1; mon_en = 1'b1;

    do_req(2'b01, 2'b01, 8'h03, 8'hA5, 8'h00, 8'h00, 0);
    idle(4);
    do_req(2'b10, 2'b00, 8'h00, 8'h00, 8'h03, 8'h00, 0);
    idle(4);
    for (int i = 0; i < 4; i++)
      do_req(2'b11, 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0);
    do_req(2'b01, 2'b01, 8'h40, 8'h5C, 8'h00, 8'h00, 0);
    do_req(2'b01, 2'b00, 8'h40, 8'h00, 8'h00, 8'h00, 3);
    do_req(2'b10, 2'b00, 8'h00, 8'h00, 8'h40, 8'h00, TO - 1);
    do_req(2'b01, 2'b00, 8'h40, 8'h00, 8'h00, 8'h00, HANG);
    do_req(2'b01, 2'b01, 8'h41, 8'h77, 8'h00, 8'h00, HANG);
    do_req(2'b10, 2'b00, 8'h00, 8'h00, 8'h41, 8'h00, 0);

    for (int i = 0; i < 150; i++) begin
      r  = $urandom_range(0, 9);
      wt = (r == 0) ? HANG : (r == 1) ? TO - 1 : $urandom_range(0, 3);
      do_req(2'($urandom_range(1, 3)), 2'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
             8'($urandom_range(0, 15)), 8'($urandom), wt);
      if ($urandom_range(0, 3) == 0) glitch();
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 4));
    end
    idle(0);
    drain();

    // Reset during a hung ACCESS from req0: no response, and the next tie goes to req0 again.
    do_req(2'b01, 2'b00, 8'h05, 8'h00, 8'h00, 8'h00, HANG);
    @(posedge pclk); #1;
    req_valid = 2'b00;
    repeat (4) @(posedge pclk);
    #1;
    prstn = 1'b0;
    @(posedge pclk); #1;
    prstn = 1'b1;
    sb_q.delete(); apb_q.delete();
    lg = 1'b1;
    @(negedge pclk);
    chk("post_reset_psel", psel, 0);
    chk("post_reset_penable", penable, 0);
    chk("post_reset_rsp_valid", rsp_valid, 0);
    do_req(2'b11, 2'b00, 8'h05, 8'h00, 8'h06, 8'h00, 0);
    idle(0);
    drain();
    repeat (5) @(posedge pclk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
